// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared opcodes, step indices and decode helpers for the control sequencer
package cpu_ctrl_pkg;

    localparam logic [3:0] OP_LD   = 4'b0000;
    localparam logic [3:0] OP_ST   = 4'b0001;
    localparam logic [3:0] OP_DATA = 4'b0010;
    localparam logic [3:0] OP_JMPR = 4'b0011;
    localparam logic [3:0] OP_JMP  = 4'b0100;
    localparam logic [3:0] OP_JCON = 4'b0101;
    localparam logic [3:0] OP_CLF  = 4'b0110;
    localparam logic [3:0] OP_IO   = 4'b0111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_CMP = 3'b111;

    // Bit positions of each step inside the one-hot step register.
    localparam logic [2:0] S1 = 3'd0;
    localparam logic [2:0] S2 = 3'd1;
    localparam logic [2:0] S3 = 3'd2;
    localparam logic [2:0] S4 = 3'd3;
    localparam logic [2:0] S5 = 3'd4;
    localparam logic [2:0] S6 = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } run_state_t;

    // Bit position of the final step that carries micro-ops for this instruction.
    function automatic logic [2:0] last_step(input logic [7:0] ir);
        logic [2:0] last;
        if (ir[7]) begin
            last = (ir[6:4] == ALU_CMP) ? S5 : S6;
        end else begin
            case (ir[7:4])
                OP_LD, OP_ST, OP_JMP: last = S5;
                OP_DATA, OP_JCON:     last = S6;
                default:              last = S4;
            endcase
        end
        return last;
    endfunction

endpackage

// File: rtl/ctrl_step_counter.sv
// rtl/ctrl_step_counter.sv - one-hot step register with idle, stall hold, early wrap and halt
module ctrl_step_counter
    import cpu_ctrl_pkg::*;
#(
    parameter int NUM_STEPS = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 wrap,
    input  logic                 halt_req,
    output logic [NUM_STEPS-1:0] step,
    output logic                 halted
);

    localparam logic [NUM_STEPS-1:0] FIRST = {{(NUM_STEPS-1){1'b0}}, 1'b1};

    run_state_t           state;
    run_state_t           state_next;
    logic [NUM_STEPS-1:0] step_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
            step  <= '0;
        end else begin
            state <= state_next;
            step  <= step_next;
        end
    end

    always_comb begin
        state_next = state;
        step_next  = step;
        case (state)
            ST_IDLE: begin
                state_next = ST_RUN;
                step_next  = FIRST;
            end
            ST_RUN: begin
                // A stalled RAM step keeps its strobes up until mem_ready.
                if (!stall) begin
                    if (halt_req) begin
                        state_next = ST_HALT;
                        step_next  = '0;
                    end else if (wrap || step[NUM_STEPS-1]) begin
                        step_next = FIRST;
                    end else begin
                        step_next = step << 1;
                    end
                end
            end
            ST_HALT: begin
                step_next = '0;
            end
            default: begin
                state_next = ST_IDLE;
                step_next  = '0;
            end
        endcase
    end

    assign halted = (state == ST_HALT);

endmodule

// File: rtl/ctrl_seq_gen.sv
// rtl/ctrl_seq_gen.sv - micro-sequenced control unit: instruction decode and bus/set strobes
module ctrl_seq_gen
    import cpu_ctrl_pkg::*;
#(
    parameter int NUM_STEPS = 6,
    parameter bit EARLY_END = 1'b1,
    parameter bit RAM_WAIT  = 1'b1
) (
    input  logic                 dclk,
    input  logic                 reset,
    input  logic [7:0]           ir,
    input  logic [3:0]           flags,
    input  logic                 mem_ready,
    output logic [NUM_STEPS-1:0] step,
    output logic                 bus1,
    output logic                 e_iar,
    output logic                 e_ram,
    output logic                 e_acc,
    output logic                 e_disp_unused,
    output logic [3:0]           e_reg,
    output logic                 s_ir,
    output logic                 s_mar,
    output logic                 s_iar,
    output logic                 s_acc,
    output logic                 s_ram,
    output logic                 s_tmp,
    output logic                 s_flags,
    output logic                 s_disp,
    output logic [3:0]           s_reg,
    output logic [2:0]           alu_op,
    output logic                 halted
);

    logic [3:0] opcode;
    logic [3:0] ra_sel;
    logic [3:0] rb_sel;
    logic       cond;
    logic [2:0] last_idx;
    logic       wrap;
    logic       stall;
    logic       halt_req;

    assign opcode   = ir[7:4];
    assign ra_sel   = 4'b0001 << ir[3:2];
    assign rb_sel   = 4'b0001 << ir[1:0];
    assign cond     = |(ir[3:0] & flags);
    assign last_idx = last_step(ir);
    assign wrap     = EARLY_END && step[last_idx];
    assign stall    = RAM_WAIT && !mem_ready && (e_ram || s_ram);
    assign halt_req = step[S4] && !ir[7] && (opcode == OP_IO) && ir[3];

    assign e_disp_unused = 1'b0;

    ctrl_step_counter #(
        .NUM_STEPS(NUM_STEPS)
    ) u_step_counter (
        .clk      (dclk),
        .reset    (reset),
        .stall    (stall),
        .wrap     (wrap),
        .halt_req (halt_req),
        .step     (step),
        .halted   (halted)
    );

    always_comb begin
        bus1    = 1'b0;
        e_iar   = 1'b0;
        e_ram   = 1'b0;
        e_acc   = 1'b0;
        e_reg   = 4'b0000;
        s_ir    = 1'b0;
        s_mar   = 1'b0;
        s_iar   = 1'b0;
        s_acc   = 1'b0;
        s_ram   = 1'b0;
        s_tmp   = 1'b0;
        s_flags = 1'b0;
        s_disp  = 1'b0;
        s_reg   = 4'b0000;
        alu_op  = ALU_ADD;
        if (step[S1]) begin
            bus1  = 1'b1;
            e_iar = 1'b1;
            s_mar = 1'b1;
            s_acc = 1'b1;
        end else if (step[S2]) begin
            e_ram = 1'b1;
            s_ir  = 1'b1;
        end else if (step[S3]) begin
            e_acc = 1'b1;
            s_iar = 1'b1;
        end else if (ir[7]) begin
            if (step[S4]) begin
                e_reg = rb_sel;
                s_tmp = 1'b1;
            end else if (step[S5]) begin
                e_reg   = ra_sel;
                alu_op  = ir[6:4];
                s_acc   = 1'b1;
                s_flags = 1'b1;
            end else if (step[S6] && ir[6:4] != ALU_CMP) begin
                e_acc = 1'b1;
                s_reg = rb_sel;
            end
        end else begin
            case (opcode)
                OP_LD: begin
                    if (step[S4]) begin
                        e_reg = ra_sel;
                        s_mar = 1'b1;
                    end else if (step[S5]) begin
                        e_ram = 1'b1;
                        s_reg = rb_sel;
                    end
                end
                OP_ST: begin
                    if (step[S4]) begin
                        e_reg = ra_sel;
                        s_mar = 1'b1;
                    end else if (step[S5]) begin
                        e_reg = rb_sel;
                        s_ram = 1'b1;
                    end
                end
                OP_DATA: begin
                    if (step[S4]) begin
                        bus1  = 1'b1;
                        e_iar = 1'b1;
                        s_mar = 1'b1;
                        s_acc = 1'b1;
                    end else if (step[S5]) begin
                        e_ram = 1'b1;
                        s_reg = rb_sel;
                    end else if (step[S6]) begin
                        e_acc = 1'b1;
                        s_iar = 1'b1;
                    end
                end
                OP_JMPR: begin
                    if (step[S4]) begin
                        e_reg = rb_sel;
                        s_iar = 1'b1;
                    end
                end
                OP_JMP: begin
                    if (step[S4]) begin
                        e_iar = 1'b1;
                        s_mar = 1'b1;
                    end else if (step[S5]) begin
                        e_ram = 1'b1;
                        s_iar = 1'b1;
                    end
                end
                OP_JCON: begin
                    if (step[S4]) begin
                        bus1  = 1'b1;
                        e_iar = 1'b1;
                        s_mar = 1'b1;
                        s_acc = 1'b1;
                    end else if (step[S5]) begin
                        e_acc = 1'b1;
                        s_iar = 1'b1;
                    end else if (step[S6] && cond) begin
                        // Untaken jumps still spend the s6 cycle, just without strobes.
                        e_ram = 1'b1;
                        s_iar = 1'b1;
                    end
                end
                OP_CLF: begin
                    if (step[S4]) begin
                        bus1    = 1'b1;
                        s_flags = 1'b1;
                    end
                end
                OP_IO: begin
                    if (step[S4] && !ir[3]) begin
                        e_reg  = rb_sel;
                        s_disp = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_seq_gen.sv
// tb/tb_ctrl_seq_gen.sv - self-checking bench for ctrl_seq_gen against a step-level behavioural model
module tb_ctrl_seq_gen;

    typedef struct packed {
        logic       bus1;
        logic       e_iar;
        logic       e_ram;
        logic       e_acc;
        logic [3:0] e_reg;
        logic       s_ir;
        logic       s_mar;
        logic       s_iar;
        logic       s_acc;
        logic       s_ram;
        logic       s_tmp;
        logic       s_flags;
        logic       s_disp;
        logic [3:0] s_reg;
        logic [2:0] alu_op;
    } uops_t;

    logic       dclk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] ir = 8'h00;
    logic [3:0] flags = 4'h0;
    logic       mem_ready = 1'b1;

    uops_t      act_a, act_b;
    logic [5:0] step_a;
    logic [7:0] step_b;
    logic       halted_a, halted_b, edisp_a, edisp_b;

    int checks = 0;
    int errors = 0;
    int mstp [2] = '{0, 0};
    bit mhalt [2] = '{1'b0, 1'b0};
    bit armed = 1'b0;

    always #5 dclk = ~dclk;

    ctrl_seq_gen #(.NUM_STEPS(6), .EARLY_END(1'b1), .RAM_WAIT(1'b1)) dut_a (
        .dclk(dclk), .reset(reset), .ir(ir), .flags(flags), .mem_ready(mem_ready),
        .step(step_a), .bus1(act_a.bus1), .e_iar(act_a.e_iar), .e_ram(act_a.e_ram),
        .e_acc(act_a.e_acc), .e_disp_unused(edisp_a), .e_reg(act_a.e_reg),
        .s_ir(act_a.s_ir), .s_mar(act_a.s_mar), .s_iar(act_a.s_iar), .s_acc(act_a.s_acc),
        .s_ram(act_a.s_ram), .s_tmp(act_a.s_tmp), .s_flags(act_a.s_flags),
        .s_disp(act_a.s_disp), .s_reg(act_a.s_reg), .alu_op(act_a.alu_op), .halted(halted_a)
    );

    ctrl_seq_gen #(.NUM_STEPS(8), .EARLY_END(1'b0), .RAM_WAIT(1'b0)) dut_b (
        .dclk(dclk), .reset(reset), .ir(ir), .flags(flags), .mem_ready(mem_ready),
        .step(step_b), .bus1(act_b.bus1), .e_iar(act_b.e_iar), .e_ram(act_b.e_ram),
        .e_acc(act_b.e_acc), .e_disp_unused(edisp_b), .e_reg(act_b.e_reg),
        .s_ir(act_b.s_ir), .s_mar(act_b.s_mar), .s_iar(act_b.s_iar), .s_acc(act_b.s_acc),
        .s_ram(act_b.s_ram), .s_tmp(act_b.s_tmp), .s_flags(act_b.s_flags),
        .s_disp(act_b.s_disp), .s_reg(act_b.s_reg), .alu_op(act_b.alu_op), .halted(halted_b)
    );

    function automatic int num_steps(int i);
        return (i == 0) ? 6 : 8;
    endfunction

    function automatic bit early(int i);
        return i == 0;
    endfunction

    function automatic bit ram_wait(int i);
        return i == 0;
    endfunction

    // Unstalled cycle count of each instruction class.
    function automatic int instr_len(logic [7:0] v);
        if (v[7]) return (v[6:4] == 3'b111) ? 5 : 6;
        case (v[6:4])
            3'd0, 3'd1, 3'd4: return 5;
            3'd2, 3'd5:       return 6;
            default:          return 4;
        endcase
    endfunction

    // Micro-operations asserted during step number stp (1-based, 0 = idle).
    function automatic uops_t model_uops(int stp, logic [7:0] v, logic [3:0] fl);
        uops_t u;
        logic [3:0] ra1, rb1;
        bit taken;
        u = '0;
        ra1 = 4'b0001 << v[3:2];
        rb1 = 4'b0001 << v[1:0];
        taken = (v[3] && fl[3]) || (v[2] && fl[2]) || (v[1] && fl[1]) || (v[0] && fl[0]);
        if (stp == 1) begin u.bus1 = 1; u.e_iar = 1; u.s_mar = 1; u.s_acc = 1; end
        else if (stp == 2) begin u.e_ram = 1; u.s_ir = 1; end
        else if (stp == 3) begin u.e_acc = 1; u.s_iar = 1; end
        else if (v[7]) begin
            if (stp == 4) begin u.e_reg = rb1; u.s_tmp = 1; end
            if (stp == 5) begin u.e_reg = ra1; u.alu_op = v[6:4]; u.s_acc = 1; u.s_flags = 1; end
            if (stp == 6 && v[6:4] != 3'b111) begin u.e_acc = 1; u.s_reg = rb1; end
        end else begin
            case ({v[6:4], 4'(stp)})
                {3'd0, 4'd4}, {3'd1, 4'd4}: begin u.e_reg = ra1; u.s_mar = 1; end
                {3'd0, 4'd5}:               begin u.e_ram = 1; u.s_reg = rb1; end
                {3'd1, 4'd5}:               begin u.e_reg = rb1; u.s_ram = 1; end
                {3'd2, 4'd4}, {3'd5, 4'd4}: begin u.bus1 = 1; u.e_iar = 1; u.s_mar = 1; u.s_acc = 1; end
                {3'd2, 4'd5}:               begin u.e_ram = 1; u.s_reg = rb1; end
                {3'd2, 4'd6}, {3'd5, 4'd5}: begin u.e_acc = 1; u.s_iar = 1; end
                {3'd3, 4'd4}:               begin u.e_reg = rb1; u.s_iar = 1; end
                {3'd4, 4'd4}:               begin u.e_iar = 1; u.s_mar = 1; end
                {3'd4, 4'd5}:               begin u.e_ram = 1; u.s_iar = 1; end
                {3'd5, 4'd6}:               begin u.e_ram = taken; u.s_iar = taken; end
                {3'd6, 4'd4}:               begin u.bus1 = 1; u.s_flags = 1; end
                {3'd7, 4'd4}:               begin u.e_reg = v[3] ? 4'b0000 : rb1; u.s_disp = !v[3]; end
                default: ;
            endcase
        end
        return u;
    endfunction

    function automatic bit touches_ram(int stp, logic [7:0] v, logic [3:0] fl);
        uops_t u;
        u = model_uops(stp, v, fl);
        return u.e_ram || u.s_ram;
    endfunction

    function automatic logic [31:0] onehot(int s);
        return (s == 0) ? 32'd0 : (32'd1 << (s - 1));
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge dclk) begin
        armed <= 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                mstp[i]  <= 0;
                mhalt[i] <= 1'b0;
            end else if (mhalt[i]) begin
                mstp[i] <= 0;
            end else if (mstp[i] == 0) begin
                mstp[i] <= 1;
            end else if (ram_wait(i) && !mem_ready && touches_ram(mstp[i], ir, flags)) begin
                mstp[i] <= mstp[i];
            end else if (mstp[i] == 4 && ir[7:4] == 4'h7 && ir[3]) begin
                mstp[i]  <= 0;
                mhalt[i] <= 1'b1;
            end else if (mstp[i] == num_steps(i) || (early(i) && mstp[i] == instr_len(ir))) begin
                mstp[i] <= 1;
            end else begin
                mstp[i] <= mstp[i] + 1;
            end
        end
    end

    always @(negedge dclk) begin
        if (armed) begin
            check("a.step", 32'(step_a), onehot(mstp[0]));
            check("a.uops", 32'(act_a), 32'(model_uops(mstp[0], ir, flags)));
            check("a.halted", 32'(halted_a), 32'(mhalt[0]));
            check("a.e_disp", 32'(edisp_a), 32'd0);
            check("b.step", 32'(step_b), onehot(mstp[1]));
            check("b.uops", 32'(act_b), 32'(model_uops(mstp[1], ir, flags)));
            check("b.halted", 32'(halted_b), 32'(mhalt[1]));
            check("b.e_disp", 32'(edisp_b), 32'd0);
        end
    end

    task automatic tick();
        @(posedge dclk);
        #1;
    endtask

    task automatic sync(int i);
        int n;
        n = 0;
        while (mstp[i] != 1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL sync%0d: model never reached step 1 within 20 cycles", i);
        end
    endtask

    initial begin
        logic [7:0] v;

        repeat (3) begin
            tick();
            check("rst.step", 32'(step_a), 32'd0);
            check("rst.uops", 32'(act_a), 32'd0);
        end
        reset = 1'b1;
        tick();
        check("rel.step", 32'(step_a), 32'b000001);
        check("rel.fetch", {act_a.bus1, act_a.e_iar, act_a.s_mar, act_a.s_acc, act_a.e_ram}, 5'b11110);

        // LD 0x00 runs to completion, then ADD r1,r2.
        sync(0);
        ir = 8'h86;
        repeat (3) tick();
        check("add.s4.step", 32'(step_a), 32'b001000);
        check("add.s4", {act_a.e_reg, act_a.s_tmp}, {4'b0100, 1'b1});
        tick();
        check("add.s5", {act_a.e_reg, act_a.alu_op, act_a.s_acc, act_a.s_flags}, {4'b0010, 3'b000, 2'b11});
        tick();
        check("add.s6", {act_a.e_acc, act_a.s_reg}, {1'b1, 4'b0100});
        tick();
        check("add.wrap", 32'(step_a), 32'b000001);

        ir = 8'h58;
        flags = 4'b1000;
        repeat (5) tick();
        check("jcon_t.step", 32'(step_a), 32'b100000);
        check("jcon_t.s6", {act_a.e_ram, act_a.s_iar}, 2'b11);
        tick();
        check("jcon_t.wrap", 32'(step_a), 32'b000001);
        flags = 4'b0000;
        repeat (5) tick();
        check("jcon_n.step", 32'(step_a), 32'b100000);
        check("jcon_n.s6", {act_a.e_ram, act_a.s_iar}, 2'b00);
        tick();
        check("jcon_n.wrap", 32'(step_a), 32'b000001);

        ir = 8'h05;
        repeat (3) tick();
        check("ld.s4", {act_a.e_reg, act_a.s_mar}, {4'b0010, 1'b1});
        tick();
        mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("ld.stall.step", 32'(step_a), 32'b010000);
            check("ld.stall.s5", {act_a.e_ram, act_a.s_reg}, {1'b1, 4'b0010});
            if (k == 3) mem_ready = 1'b1;
            tick();
        end
        check("ld.wrap", 32'(step_a), 32'b000001);

        ir = 8'h32;
        sync(1);
        repeat (3) tick();
        check("jmpr.s4.step", 32'(step_b), 32'b00001000);
        check("jmpr.s4", {act_b.e_reg, act_b.s_iar}, {4'b0100, 1'b1});
        for (int k = 5; k <= 8; k++) begin
            tick();
            check("jmpr.idle.step", 32'(step_b), 32'd1 << (k - 1));
            check("jmpr.idle.uops", 32'(act_b), 32'd0);
        end
        tick();
        check("jmpr.wrap", 32'(step_b), 32'b00000001);

        for (int n = 0; n < 3000; n++) begin
            tick();
            if (mstp[0] == 1 && $urandom_range(0, 1) == 1) begin
                v = 8'($urandom);
                if (v[7:4] == 4'h7) v[3] = 1'b0;
                ir = v;
            end
            flags = 4'($urandom);
            mem_ready = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 299) != 0);
        end
        reset = 1'b1;
        mem_ready = 1'b1;
        tick();

        sync(0);
        ir = 8'h78;
        repeat (3) tick();
        check("halt.s4.step", 32'(step_a), 32'b001000);
        check("halt.s4.uops", 32'(act_a), 32'd0);
        tick();
        check("halt.flag", 32'(halted_a), 32'd1);
        check("halt.step", 32'(step_a), 32'd0);
        repeat (20) begin
            mem_ready = 1'($urandom);
            tick();
            check("halt.hold", {halted_a, step_a, 23'(act_a)}, {1'b1, 6'd0, 23'd0});
        end
        check("halt.b", {halted_b, step_b}, {1'b1, 8'd0});
        reset = 1'b0;
        tick();
        check("halt.rst", {halted_a, step_a}, {1'b0, 6'd0});
        reset = 1'b1;
        tick();
        check("halt.rel", {halted_a, step_a, step_b}, {1'b0, 6'b000001, 8'b00000001});

        @(negedge dclk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
